// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg : opcodes, status-flag bit positions and sequencer state encoding
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package alu_pkg;

  localparam logic [5:0] OP_MOVE   = 6'd3;
  localparam logic [5:0] OP_NOT    = 6'd4;
  localparam logic [5:0] OP_AND    = 6'd5;
  localparam logic [5:0] OP_OR     = 6'd6;
  localparam logic [5:0] OP_SHIFTR = 6'd7;
  localparam logic [5:0] OP_SHIFTL = 6'd8;
  localparam logic [5:0] OP_ADD    = 6'd9;
  localparam logic [5:0] OP_SUB    = 6'd10;
  localparam logic [5:0] OP_TEST   = 6'd11;

  localparam int FLAG_C = 4;
  localparam int FLAG_L = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  function automatic logic op_is_legal(input logic [5:0] op);
    return (op >= OP_MOVE) && (op <= OP_TEST);
  endfunction

  function automatic logic op_is_shift(input logic [5:0] op);
    return (op == OP_SHIFTL) || (op == OP_SHIFTR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_flag_calc.sv
// ---------------------------------------------------------------------------
// alu_flag_calc : next {C,L,F,Z,N} status from opcode, operands and result
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_flag_calc
  import alu_pkg::*;
(
  input  logic [5:0]  i_op,
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic [15:0] i_res,
  input  logic [4:0]  i_flags,
  output logic [4:0]  o_flags
);

  logic w_carry;
  logic w_borrow;

  // A 16-bit sum wraps below A exactly when the 17th bit would be set.
  assign w_carry  = (i_a + i_b) < i_a;
  assign w_borrow = i_a < i_b;

  always_comb begin
    o_flags = i_flags;
    case (i_op)
      OP_ADD: begin
        o_flags[FLAG_C] = w_carry;
        o_flags[FLAG_F] = (i_a[15] == i_b[15]) && (i_res[15] != i_a[15]);
        o_flags[FLAG_Z] = (i_res == 16'h0000);
        o_flags[FLAG_N] = i_res[15];
      end
      OP_SUB, OP_TEST: begin
        o_flags[FLAG_C] = w_borrow;
        o_flags[FLAG_L] = w_borrow;
        o_flags[FLAG_F] = (i_a[15] != i_b[15]) && (i_res[15] != i_a[15]);
        o_flags[FLAG_Z] = (i_a == i_b);
        o_flags[FLAG_N] = i_res[15];
      end
      OP_NOT, OP_AND, OP_OR, OP_SHIFTR, OP_SHIFTL: begin
        o_flags[FLAG_Z] = (i_res == 16'h0000);
        o_flags[FLAG_N] = i_res[15];
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer : issue/execute controller with register file and flags
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter  int REG_COUNT = 16,
  parameter  int MAX_SHIFT = 16,
  localparam int AW        = $clog2(REG_COUNT)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          issue_valid,
  output logic          issue_ready,
  input  logic [5:0]    issue_opcode,
  input  logic [AW-1:0] issue_rdest,
  input  logic [AW-1:0] issue_rsrc,
  input  logic          issue_imm_en,
  input  logic [15:0]   issue_imm,
  output logic [5:0]    alu_instruction,
  output logic [15:0]   alu_a,
  output logic [15:0]   alu_b,
  input  logic [15:0]   alu_result,
  output logic          done,
  output logic          illegal,
  output logic [4:0]    flags,
  input  logic [AW-1:0] dbg_addr,
  output logic [15:0]   dbg_data
);

  localparam int            CW        = $clog2(MAX_SHIFT + 1);
  localparam logic [CW-1:0] C_MAX_CNT = CW'(MAX_SHIFT);

  state_t        r_state;
  state_t        w_next;
  logic [15:0]   r_rf [REG_COUNT];
  logic [5:0]    r_op;
  logic [AW-1:0] r_rdest;
  logic [5:0]    r_alu_op;
  logic [15:0]   r_opa;
  logic [15:0]   r_opb;
  logic [15:0]   r_res;
  logic [CW-1:0] r_cnt;
  logic [4:0]    r_flags;
  logic [4:0]    r_nflags;

  logic          w_accept;
  logic          w_legal;
  logic          w_shift;
  logic          w_exec_done;
  logic [15:0]   w_opb_in;
  logic [CW-1:0] w_cnt_in;
  logic [15:0]   w_res;
  logic [4:0]    w_calc_flags;

  assign w_accept    = (r_state == ST_IDLE) && issue_valid;
  assign w_opb_in    = issue_imm_en ? issue_imm : r_rf[issue_rsrc];
  assign w_cnt_in    = (w_opb_in >= 16'(MAX_SHIFT)) ? C_MAX_CNT : w_opb_in[CW-1:0];
  assign w_legal     = op_is_legal(r_op);
  assign w_shift     = op_is_shift(r_op);
  assign w_exec_done = !w_shift || (r_cnt <= CW'(1));
  // A zero-count shift retires the unshifted operand rather than one ALU step.
  assign w_res       = (w_shift && (r_cnt == '0)) ? r_opa : alu_result;

  alu_flag_calc u_flag_calc (
    .i_op    (r_op),
    .i_a     (r_opa),
    .i_b     (r_opb),
    .i_res   (w_res),
    .i_flags (r_flags),
    .o_flags (w_calc_flags)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    issue_ready = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        issue_ready = 1'b1;
        if (issue_valid) w_next = ST_EXEC;
      end
      ST_EXEC: if (w_exec_done) w_next = ST_WB;
      ST_WB: begin
        done    = 1'b1;
        illegal = !w_legal;
        w_next  = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < REG_COUNT; i++) r_rf[i] <= '0;
      r_op     <= '0;
      r_rdest  <= '0;
      r_alu_op <= '0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_res    <= '0;
      r_cnt    <= '0;
      r_flags  <= '0;
      r_nflags <= '0;
    end else begin
      if (w_accept) begin
        r_op    <= issue_opcode;
        r_rdest <= issue_rdest;
        r_cnt   <= w_cnt_in;
        if (op_is_legal(issue_opcode)) begin
          r_alu_op <= issue_opcode;
          r_opa    <= r_rf[issue_rdest];
          r_opb    <= w_opb_in;
        end
      end
      if (r_state == ST_EXEC) begin
        if (w_exec_done) begin
          r_res    <= w_res;
          r_nflags <= w_calc_flags;
          r_alu_op <= OP_MOVE;
          r_opa    <= '0;
          r_opb    <= '0;
        end else begin
          r_opa <= alu_result;
          r_cnt <= r_cnt - CW'(1);
        end
      end
      if (r_state == ST_WB) begin
        r_flags <= r_nflags;
        if (w_legal && (r_op != OP_TEST)) r_rf[r_rdest] <= r_res;
      end
    end
  end

  assign alu_instruction = r_alu_op;
  assign alu_a           = r_opa;
  assign alu_b           = r_opb;
  assign flags           = r_flags;
  assign dbg_data        = r_rf[dbg_addr];

endmodule

`default_nettype wire
